// File: rtl/drr_pkg.sv
// Shared definitions for the DRR rank engine.
//  - Field widths of the class state and the PIFO rank word.
//  - drr_state_t: per-class {ovf, round, credit}.
//  - drr_req_t:   one latched rank request.
//  - pack_rank(): builds {1'b1, ovf, round, zero address field}.
package drr_pkg;

    localparam int DRR_CLASS_W    = 5;
    localparam int DRR_WEIGHT_W   = 16;
    localparam int DRR_OVF_W      = 1;
    localparam int DRR_ROUND_W    = 18;
    localparam int DRR_ADDR_W     = 12;
    localparam int DRR_RESULT_W   = 32;
    localparam int DRR_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [DRR_OVF_W-1:0]    ovf;
        logic [DRR_ROUND_W-1:0]  round;
        logic [DRR_WEIGHT_W-1:0] credit;
    } drr_state_t;

    typedef struct packed {
        logic [DRR_CLASS_W-1:0]  cls;
        logic [DRR_WEIGHT_W-1:0] weight;
        logic [DRR_WEIGHT_W-1:0] quot;
        logic [DRR_WEIGHT_W-1:0] rem;
    } drr_req_t;

    function automatic logic [DRR_RESULT_W-1:0] pack_rank(
        input logic [DRR_OVF_W-1:0]   ovf,
        input logic [DRR_ROUND_W-1:0] round
    );
        return {1'b1, ovf, round, {DRR_ADDR_W{1'b0}}};
    endfunction

endpackage

// File: rtl/drr_out_fifo.sv
// Synchronous output FIFO for rank words.
// Ports:
//  clk, rstn         clock, asynchronous active-low reset (clears contents)
//  push, push_data   write one entry
//  pop               consume head entry when head_valid
//  head_valid        FIFO non-empty
//  head_data         current head entry; stable until popped
//  count             number of stored entries (0..DEPTH)
module drr_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop     = pop && (count != '0);
    // A push into a full FIFO is legal when the head leaves the same cycle.
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/drr_engine_v3.sv
// Pipelined DRR rank calculator feeding the PIFO insert path.
// Two register stages after the request handshake:
//  S0: request latched; class state read (with forwarding from S1 / clear).
//  S1: new state computed, written back, rank pushed into the output FIFO.
// Ports:
//  clk, rstn                    clock, asynchronous active-low reset
//  req_valid/req_ready          request handshake (class, weight, len/weight Q and R)
//  last_pifo_*                  PIFO head snapshot, registered on last_pifo_valid
//  clr_valid, clr_class_id      zero one class's state (always accepted)
//  resp_valid/resp_ready        output FIFO head handshake
//  resp_data                    {1'b1, ovf, round, zero address field}
module drr_engine_v3 import drr_pkg::*; #(
    parameter int CLASS_WIDTH         = DRR_CLASS_W,
    parameter int WEIGHT_WIDTH        = DRR_WEIGHT_W,
    parameter int PIFO_OVERFLOW_WIDTH = DRR_OVF_W,
    parameter int PIFO_ROUND_WIDTH    = DRR_ROUND_W,
    parameter int PIFO_ADDR_WIDTH     = DRR_ADDR_W,
    parameter int RESULT_WIDTH        = DRR_RESULT_W,
    parameter int OUT_FIFO_DEPTH      = DRR_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [CLASS_WIDTH-1:0]         req_class_id,
    input  logic [WEIGHT_WIDTH-1:0]        req_class_weight,
    input  logic [WEIGHT_WIDTH-1:0]        req_div_quotient,
    input  logic [WEIGHT_WIDTH-1:0]        req_div_remain,
    input  logic                           last_pifo_valid,
    input  logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow,
    input  logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round,
    input  logic                           clr_valid,
    input  logic [CLASS_WIDTH-1:0]         clr_class_id,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [RESULT_WIDTH-1:0]        resp_data
);

    localparam int NUM_CLASSES = 1 << CLASS_WIDTH;
    localparam int STAGES      = 1;
    localparam int RW          = PIFO_ROUND_WIDTH;
    localparam int WW          = WEIGHT_WIDTH;
    localparam int OW          = PIFO_OVERFLOW_WIDTH;
    localparam int CNT_W       = $clog2(OUT_FIFO_DEPTH) + 1;

    // The state/request structs are sized by the package, so the
    // parameters must agree with it.
    if (RESULT_WIDTH != 1 + PIFO_OVERFLOW_WIDTH + PIFO_ROUND_WIDTH + PIFO_ADDR_WIDTH) begin : g_bad_result
        $error("drr_engine_v3: RESULT_WIDTH must equal 1+OVF+ROUND+ADDR");
    end
    if (CLASS_WIDTH != DRR_CLASS_W || WEIGHT_WIDTH != DRR_WEIGHT_W ||
        PIFO_OVERFLOW_WIDTH != DRR_OVF_W || PIFO_ROUND_WIDTH != DRR_ROUND_W ||
        PIFO_ADDR_WIDTH != DRR_ADDR_W || RESULT_WIDTH != DRR_RESULT_W) begin : g_bad_pkg
        $error("drr_engine_v3: parameters disagree with drr_pkg widths");
    end
    if (OUT_FIFO_DEPTH < 2 || (OUT_FIFO_DEPTH & (OUT_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("drr_engine_v3: OUT_FIFO_DEPTH must be a power of 2, >= 2");
    end

    drr_state_t            st_mem [NUM_CLASSES];
    logic [OW-1:0]         h_ovf;
    logic [RW-1:0]         h_round;
    logic [STAGES:0]       vld_pipe;      // [0]=S0 occupied, [1]=S1 occupied
    drr_req_t              s0_req;
    drr_req_t              s1_req;
    drr_state_t            s1_st;
    drr_state_t            s0_rd;
    drr_state_t            s1_nxt;
    logic                  rdy_en;
    logic                  accept;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        in_flight;
    logic                  stale;
    logic [RW:0]           sum;
    logic [WW-1:0]         gap;

    // Credit-based admission: every accepted request already owns a FIFO
    // slot, so the S1 push can never be refused.
    assign in_flight = {1'b0, fifo_count} + (CNT_W+1)'(vld_pipe[0]) + (CNT_W+1)'(vld_pipe[1]);
    assign req_ready = rdy_en && (in_flight < (CNT_W+1)'(OUT_FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    // S0 read. A clear landing this cycle zeroes the class at the same edge
    // S1 would write it, so it beats the S1 forward.
    always_comb begin
        s0_rd = st_mem[s0_req.cls];
        if (clr_valid && (clr_class_id == s0_req.cls))
            s0_rd = '0;
        else if (vld_pipe[1] && (s1_req.cls == s0_req.cls))
            s0_rd = s1_nxt;
    end

    // S1 compute.
    always_comb begin
        s1_nxt = s1_st;
        sum    = '0;
        gap    = '0;
        stale  = (s1_st.ovf != h_ovf) && (h_round < s1_st.round);
        if (stale) begin
            // Class state belongs to a previous epoch: restart at the head.
            s1_nxt.ovf    = h_ovf;
            s1_nxt.round  = h_round;
            s1_nxt.credit = s1_req.weight - WW'(1);
        end else begin
            if (s1_req.rem > s1_st.credit) begin
                // credit + W - R computed as W - (R - credit): both steps are
                // exact because R > credit and R < W.
                gap           = s1_req.rem - s1_st.credit;
                s1_nxt.credit = s1_req.weight - gap;
                sum           = {1'b0, s1_st.round} + (RW+1)'(s1_req.quot) + (RW+1)'(1);
            end else begin
                s1_nxt.credit = s1_st.credit - s1_req.rem;
                sum           = {1'b0, s1_st.round} + (RW+1)'(s1_req.quot);
            end
            if (sum[RW]) begin
                s1_nxt.round = sum[RW-1:0];
                s1_nxt.ovf   = s1_st.ovf + OW'(1);
            end else if (sum[RW-1:0] < h_round) begin
                // Lagging class catches up to the PIFO head.
                s1_nxt.round  = h_round;
                s1_nxt.credit = s1_req.weight - WW'(1);
            end else begin
                s1_nxt.round = sum[RW-1:0];
            end
        end
    end

    // Class state: S1 write-back, clear applied last so it wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CLASSES; i++) st_mem[i] <= '0;
        end else begin
            if (vld_pipe[1]) st_mem[s1_req.cls] <= s1_nxt;
            if (clr_valid)   st_mem[clr_class_id] <= '0;
        end
    end

    // Pipeline registers and head snapshot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_en   <= 1'b0;
            vld_pipe <= '0;
            s0_req   <= '0;
            s1_req   <= '0;
            s1_st    <= '0;
            h_ovf    <= '0;
            h_round  <= '0;
        end else begin
            rdy_en   <= 1'b1;
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            if (accept) begin
                s0_req.cls    <= req_class_id;
                s0_req.weight <= req_class_weight;
                s0_req.quot   <= req_div_quotient;
                s0_req.rem    <= req_div_remain;
            end
            if (vld_pipe[0]) begin
                s1_req <= s0_req;
                s1_st  <= s0_rd;
            end
            if (last_pifo_valid) begin
                h_ovf   <= last_pifo_overflow;
                h_round <= last_pifo_round;
            end
        end
    end

    drr_out_fifo #(
        .WIDTH (RESULT_WIDTH),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (vld_pipe[1]),
        .push_data  (pack_rank(s1_nxt.ovf, s1_nxt.round)),
        .pop        (resp_ready),
        .head_valid (resp_valid),
        .head_data  (resp_data),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_drr_engine_v3.sv
module tb_drr_engine_v3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_class_id;
    logic [15:0] req_class_weight;
    logic [15:0] req_div_quotient;
    logic [15:0] req_div_remain;
    logic        last_pifo_valid;
    logic        last_pifo_overflow;
    logic [17:0] last_pifo_round;
    logic        clr_valid;
    logic [4:0]  clr_class_id;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;

    always #5 clk = ~clk;

    drr_engine_v3 dut (
        .clk                (clk),
        .rstn               (rstn),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_class_id       (req_class_id),
        .req_class_weight   (req_class_weight),
        .req_div_quotient   (req_div_quotient),
        .req_div_remain     (req_div_remain),
        .last_pifo_valid    (last_pifo_valid),
        .last_pifo_overflow (last_pifo_overflow),
        .last_pifo_round    (last_pifo_round),
        .clr_valid          (clr_valid),
        .clr_class_id       (clr_class_id),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_data          (resp_data)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_resp = '0;

    // Reference DRR state, updated in acceptance order.
    int m_ovf[32];
    int m_round[32];
    int m_credit[32];
    int h_o = 0;
    int h_r = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_ovf[i] = 0; m_round[i] = 0; m_credit[i] = 0;
        end
        h_o = 0;
        h_r = 0;
    endfunction

    function automatic logic [31:0] model(input int c, input int w, input int q, input int r);
        int          o, rd, cr, s;
        logic [17:0] rfield;
        logic        ofield;
        o  = m_ovf[c];
        rd = m_round[c];
        cr = m_credit[c];
        if (o != h_o && h_r < rd) begin
            o = h_o; rd = h_r; cr = w - 1;
        end else begin
            if (r > cr) begin cr = cr + w - r; s = rd + q + 1; end
            else        begin cr = cr - r;     s = rd + q;     end
            if (s >= 262144)  begin rd = s - 262144; o = (o + 1) % 2; end
            else if (s < h_r) begin rd = h_r; cr = w - 1; end
            else              rd = s;
        end
        m_ovf[c] = o; m_round[c] = rd; m_credit[c] = cr;
        rfield = rd[17:0];
        ofield = o[0];
        return {1'b1, ofield, rfield, 12'h000};
    endfunction

    // Scoreboard consumer: handshake seen on the falling edge completes at
    // the next rising edge.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (rstn && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", resp_data, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("sb_resp", resp_data, e);
                last_resp = resp_data;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present one request for one cycle; acc reports whether it was taken.
    task automatic req_cycle(input int c, input int w, input int q, input int r, output bit acc);
        req_valid        = 1'b1;
        req_class_id     = 5'(c);
        req_class_weight = 16'(w);
        req_div_quotient = 16'(q);
        req_div_remain   = 16'(r);
        acc = req_ready;
        if (acc) exp_q.push_back(model(c, w, q, r));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send(input int c, input int w, input int q, input int r);
        bit acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) req_cycle(c, w, q, r, acc);
        check("send_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_head(input int o, input int r);
        last_pifo_valid    = 1'b1;
        last_pifo_overflow = 1'(o);
        last_pifo_round    = 18'(r);
        @(posedge clk); #1;
        last_pifo_valid = 1'b0;
        h_o = o;
        h_r = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int nacc;
        rstn = 1'b0; req_valid = 1'b0; req_class_id = '0; req_class_weight = '0;
        req_div_quotient = '0; req_div_remain = '0; last_pifo_valid = 1'b0;
        last_pifo_overflow = 1'b0; last_pifo_round = '0; clr_valid = 1'b0;
        clr_class_id = '0; resp_ready = 1'b1;
        model_reset();

        // Reset state
        #3;
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        tick(2);
        rstn = 1'b1;
        check("ready_before_edge", {31'b0, req_ready}, 32'd0);
        tick(1);
        check("ready_after_release", {31'b0, req_ready}, 32'd1);

        // 1+2: class 3 back-to-back, latency and forwarding
        req_cycle(3, 100, 0, 40, acc);
        check("t1_accept", {31'b0, acc}, 32'd1);
        check("t1_lat1", {31'b0, resp_valid}, 32'd0);
        req_cycle(3, 100, 0, 40, acc);
        check("t2_accept", {31'b0, acc}, 32'd1);
        check("t1_lat2", {31'b0, resp_valid}, 32'd0);
        tick(1);
        check("t1_lat_valid", {31'b0, resp_valid}, 32'd1);
        check("t1_data", resp_data, 32'h80001000);
        drain();
        check("t2_data", last_resp, 32'h80001000);

        // 3: round wrap into overflow
        for (int i = 0; i < 5; i++) send(7, 1, 65535, 0);
        drain();
        check("t3_wrap", last_resp, 32'hCFFFB000);

        // 4: stale class restarts at the head
        set_head(0, 10);
        send(7, 1, 0, 0);
        drain();
        check("t4_stale", last_resp, 32'h8000A000);

        // 5: lagging class clamps to head round
        set_head(0, 1000);
        send(5, 8, 2, 0);
        drain();
        check("t5_clamp", last_resp, 32'h803E8000);

        // 6: backpressure fills exactly the FIFO depth
        resp_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            req_cycle(10 + i, 8, 2000 + i, 0, acc);
            nacc += int'(acc);
        end
        check("t6_accepted", 32'(nacc), 32'd4);
        check("t6_ready_low", {31'b0, req_ready}, 32'd0);
        check("t6_valid", {31'b0, resp_valid}, 32'd1);
        check("t6_head", resp_data, 32'h807D0000);
        tick(3);
        check("t6_head_stable", resp_data, 32'h807D0000);
        check("t6_ready_still_low", {31'b0, req_ready}, 32'd0);
        resp_ready = 1'b1;
        drain();
        check("t6_last", last_resp, 32'h807D3000);

        // 7a: clear during S1 write while the next same-class request reads
        set_head(0, 0);
        req_cycle(3, 100, 0, 10, acc);
        check("t7_acc_a", {31'b0, acc}, 32'd1);
        m_ovf[3] = 0; m_round[3] = 0; m_credit[3] = 0;
        req_cycle(3, 100, 5, 40, acc);
        check("t7_acc_b", {31'b0, acc}, 32'd1);
        clr_valid = 1'b1; clr_class_id = 5'd3;
        tick(1);
        clr_valid = 1'b0;
        drain();
        check("t7_after_clear_fwd", last_resp, 32'h80006000);

        // 7b: clear beats the S1 write in the stored state
        req_cycle(3, 100, 0, 0, acc);
        check("t7_acc_c", {31'b0, acc}, 32'd1);
        m_ovf[3] = 0; m_round[3] = 0; m_credit[3] = 0;
        tick(1);
        clr_valid = 1'b1; clr_class_id = 5'd3;
        tick(1);
        clr_valid = 1'b0;
        tick(2);
        send(3, 100, 0, 40);
        drain();
        check("t7_after_clear_mem", last_resp, 32'h80001000);

        // 8: reset mid-burst
        set_head(0, 500);
        resp_ready = 1'b0;
        req_cycle(20, 8, 1, 0, acc);
        req_cycle(21, 8, 1, 0, acc);
        req_cycle(22, 8, 1, 0, acc);
        #1;
        rstn = 1'b0;
        #1;
        check("t8_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("t8_resp_data", resp_data, 32'd0);
        check("t8_req_ready", {31'b0, req_ready}, 32'd0);
        exp_q.delete();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        resp_ready = 1'b1;
        tick(1);
        check("t8_ready_back", {31'b0, req_ready}, 32'd1);
        tick(4);
        check("t8_no_stale", {31'b0, resp_valid}, 32'd0);
        send(3, 100, 0, 70);
        drain();
        check("t8_fresh_state", last_resp, 32'h80001000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
